cam_dvp_tx: RTL

- Transmit side of the OV7670-style DVP camera bus: cam_vsync, cam_href and an 8-bit cam_data stream carrying RGB565 as two bytes per pixel, high byte first.
- Serializes 16-bit pixels from an upstream valid/ready source into that byte stream, with programmable frame/line timing.
- Used as a camera emulator feeding the capture/VGA path in simulation and on board, and as a loopback source for link bring-up.

---
 rtl/cam_dvp_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: DVP camera bus transmitter (vsync/href/8-bit data, RGB565 high byte first).
// Serializes 16-bit pixels from a valid/ready source into a byte stream with
// programmable frame/line timing. Optional internal 8-bar colour generator is
// compiled in with the macro CAM_DVP_TX_PATTERN_EN (adds the pattern_en input).
//
// Timing model: r_state/r_hcnt/r_lcnt describe the byte position being decoded;
// every output register is loaded from that decode, so the bus lags the counters
// by one cycle. pix_ready is decoded from the *next* position so that it is high
// exactly one cycle before each high-byte cycle on the bus.
module cam_dvp_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 288,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef CAM_DVP_TX_PATTERN_EN
    input  logic        pattern_en,
`endif
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        underrun
);

    localparam int L    = 2*H_ACTIVE + H_BLANK;
    localparam int HW   = (L > 1) ? $clog2(L) : 1;
    localparam int VM1  = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int VM2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int LW   = $clog2(VMAX + 1);

    localparam logic [HW-1:0] H_LAST      = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT_BYTES = HW'(2*H_ACTIVE);
    localparam logic [LW-1:0] VS_LAST = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] VB_LAST = LW'((V_BACK > 0) ? V_BACK - 1 : 0);
    localparam logic [LW-1:0] VA_LAST = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST = LW'((V_FRONT > 0) ? V_FRONT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt, w_after;
    logic [HW-1:0]   r_hcnt, w_hcnt_nxt;
    logic [LW-1:0]   r_lcnt, w_lcnt_nxt, w_lcnt_last;
    state_t          w_frame_next;

    logic            r_pix_ready, r_vsync, r_href, r_fs, r_under;
    logic [7:0]      r_data, r_lo;

    logic            w_href_cur, w_hi_cur, w_fs_cur, w_nxt_hi;
    logic            w_pat;
    logic [15:0]     w_pix;

    // Next frame after the last blank line: loop if still enabled, else park.
    assign w_frame_next = enable ? S_VSYNC : S_IDLE;

    // Next-state and counter logic; zero-length V_BACK/V_FRONT are skipped.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt + 1'b1;
        w_lcnt_nxt  = r_lcnt;
        w_lcnt_last = '0;
        w_after     = S_IDLE;
        case (r_state)
            S_VSYNC: begin
                w_lcnt_last = VS_LAST;
                w_after     = (V_BACK != 0) ? S_VBACK : S_ACTIVE;
            end
            S_VBACK: begin
                w_lcnt_last = VB_LAST;
                w_after     = S_ACTIVE;
            end
            S_ACTIVE: begin
                w_lcnt_last = VA_LAST;
                w_after     = (V_FRONT != 0) ? S_VFRONT : w_frame_next;
            end
            S_VFRONT: begin
                w_lcnt_last = VF_LAST;
                w_after     = w_frame_next;
            end
            default: begin
                w_lcnt_last = '0;
                w_after     = S_IDLE;
            end
        endcase
        if (r_state == S_IDLE) begin
            w_hcnt_nxt = '0;
            w_lcnt_nxt = '0;
            if (enable)
                w_state_nxt = S_VSYNC;
        end else if (r_hcnt == H_LAST) begin
            w_hcnt_nxt = '0;
            if (r_lcnt == w_lcnt_last) begin
                w_lcnt_nxt  = '0;
                w_state_nxt = w_after;
            end else begin
                w_lcnt_nxt = r_lcnt + 1'b1;
            end
        end
    end

    // State and position counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    // Decode of the current and next byte positions.
    assign w_href_cur = (r_state == S_ACTIVE) && (r_hcnt < H_ACT_BYTES);
    assign w_hi_cur   = w_href_cur && !r_hcnt[0];
    assign w_fs_cur   = (r_state == S_VSYNC) && (r_hcnt == '0) && (r_lcnt == '0);
    assign w_nxt_hi   = (w_state_nxt == S_ACTIVE) && (w_hcnt_nxt < H_ACT_BYTES)
                        && !w_hcnt_nxt[0];

`ifdef CAM_DVP_TX_PATTERN_EN
    logic        r_pat;
    logic [31:0] w_x8;
    logic [2:0]  w_bar;
    logic [15:0] w_bar_pix;

    // Bar index = (x*8)/H_ACTIVE, x being the pixel index within the line.
    assign w_x8  = (32'(r_hcnt) >> 1) * 32'd8;
    assign w_bar = 3'(w_x8 / 32'(H_ACTIVE));

    // Bar colour lookup, white to black.
    always_comb begin
        w_bar_pix = 16'h0000;
        case (w_bar)
            3'd0: w_bar_pix = 16'hFFFF;
            3'd1: w_bar_pix = 16'hFFE0;
            3'd2: w_bar_pix = 16'h07FF;
            3'd3: w_bar_pix = 16'h07E0;
            3'd4: w_bar_pix = 16'hF81F;
            3'd5: w_bar_pix = 16'hF800;
            3'd6: w_bar_pix = 16'h001F;
            default: w_bar_pix = 16'h0000;
        endcase
    end

    // Pattern select is captured once per frame at the start of vsync.
    always_ff @(posedge clk) begin
        if (!reset)
            r_pat <= 1'b0;
        else if (w_fs_cur)
            r_pat <= pattern_en;
    end

    assign w_pat = r_pat;
    assign w_pix = r_pat ? w_bar_pix : (pix_valid ? pix_data : 16'h0000);
`else
    assign w_pat = 1'b0;
    assign w_pix = pix_valid ? pix_data : 16'h0000;
`endif

    // Output registers: bus signals, handshake and sticky underrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix_ready <= 1'b0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_fs        <= 1'b0;
            r_under     <= 1'b0;
            r_data      <= 8'h00;
            r_lo        <= 8'h00;
        end else begin
            r_pix_ready <= w_nxt_hi && !w_pat;
            r_vsync     <= (r_state == S_VSYNC);
            r_href      <= w_href_cur;
            r_fs        <= w_fs_cur;
            // A missing pixel is replaced by black; the slot is never stalled.
            if (w_fs_cur)
                r_under <= 1'b0;
            else if (w_hi_cur && !w_pat && !pix_valid)
                r_under <= 1'b1;
            if (w_hi_cur) begin
                r_data <= w_pix[15:8];
                r_lo   <= w_pix[7:0];
            end else if (w_href_cur) begin
                r_data <= r_lo;
            end else begin
                r_data <= 8'h00;
            end
        end
    end

    assign pix_ready   = r_pix_ready;
    assign cam_vsync   = r_vsync;
    assign cam_href    = r_href;
    assign cam_data    = r_data;
    assign frame_start = r_fs;
    assign underrun    = r_under;

endmodule
